// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types for the decode-to-execute pipeline register.
//               Defines the decode control bundle and its packed width.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Decode control bundle; field order fixes the packed bit layout.
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic [3:0] alu_control;
        logic       alu_src;
        logic       reg_dst;
    } de_ctrl_t;

    localparam int DE_CTRL_W = $bits(de_ctrl_t);

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_de_hs_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : skid_buf
// Description : Generic two-slot valid/ready pipeline register with a skid
//               slot, synchronous clear, flush and occupancy output. The
//               upstream ready is a flop so the ready path is not combinational
//               through this stage.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buf #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         FLUSH,
    input  logic         S_VALID,
    output logic         S_READY,
    input  logic [W-1:0] S_DATA,
    output logic         M_VALID,
    input  logic         M_READY,
    output logic [W-1:0] M_DATA,
    output logic [1:0]   OCC
);

    logic         r_main_v;
    logic         r_skid_v;
    logic         r_ready;
    logic [W-1:0] r_main_d;
    logic [W-1:0] r_skid_d;

    logic         w_acc;
    logic         w_main_v_nx;
    logic         w_skid_v_nx;
    logic [W-1:0] w_main_d_nx;
    logic [W-1:0] w_skid_d_nx;

    assign w_acc = S_VALID & r_ready;

    // Next-state of both slots: main refills from skid first to keep FIFO order.
    always_comb begin
        w_main_v_nx = r_main_v;
        w_skid_v_nx = r_skid_v;
        w_main_d_nx = r_main_d;
        w_skid_d_nx = r_skid_d;
        if (!r_main_v || M_READY) begin
            if (r_skid_v) begin
                w_main_v_nx = 1'b1;
                w_main_d_nx = r_skid_d;
                w_skid_v_nx = w_acc;
                if (w_acc) begin
                    w_skid_d_nx = S_DATA;
                end
            end else begin
                w_main_v_nx = w_acc;
                if (w_acc) begin
                    w_main_d_nx = S_DATA;
                end
            end
        end else if (w_acc) begin
            w_skid_v_nx = 1'b1;
            w_skid_d_nx = S_DATA;
        end
    end

    // Slot registers; clear zeroes payload, flush only drops the valid bits.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main_d <= '0;
            r_skid_d <= '0;
            r_ready  <= 1'b1;
        end else if (FLUSH) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            r_main_v <= w_main_v_nx;
            r_skid_v <= w_skid_v_nx;
            r_main_d <= w_main_d_nx;
            r_skid_d <= w_skid_d_nx;
            r_ready  <= ~w_skid_v_nx;
        end
    end

    assign S_READY = r_ready;
    assign M_VALID = r_main_v;
    assign M_DATA  = r_main_d;
    assign OCC     = {1'b0, r_main_v} + {1'b0, r_skid_v};

endmodule : skid_buf
`default_nettype wire

// File: rtl/pipe_de_hs.sv
`default_nettype none
// ============================================================================
// Module      : pipe_de_hs
// Description : Decode-to-execute pipeline register for the vector datapath.
//               Packs controls, lane operands, addresses and immediate into a
//               skid buffer and gates write enables on bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_de_hs
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int AW    = 5
) (
    input  logic                   CLK,
    input  logic                   CLR,
    input  logic                   FLUSH_D,
    input  logic                   VALID_D,
    output logic                   READY_D,
    input  logic                   REG_WRITE_D,
    input  logic                   MEM_TO_REG_D,
    input  logic                   MEM_WRITE_D,
    input  logic                   ALU_SRC_D,
    input  logic                   REG_DST_D,
    input  logic [3:0]             ALU_CONTROL_D,
    input  logic [LANES*WIDTH-1:0] RD1_D,
    input  logic [LANES*WIDTH-1:0] RD2_D,
    input  logic [AW-1:0]          RA1_D,
    input  logic [AW-1:0]          RA2_D,
    input  logic [AW-1:0]          RS_D,
    input  logic [WIDTH-1:0]       SIGN_IMM_D,
    output logic                   VALID_E,
    input  logic                   READY_E,
    output logic                   REG_WRITE_E,
    output logic                   MEM_TO_REG_E,
    output logic                   MEM_WRITE_E,
    output logic                   ALU_SRC_E,
    output logic                   REG_DST_E,
    output logic [3:0]             ALU_CONTROL_E,
    output logic [LANES*WIDTH-1:0] RD1_E,
    output logic [LANES*WIDTH-1:0] RD2_E,
    output logic [AW-1:0]          RA1_E,
    output logic [AW-1:0]          RA2_E,
    output logic [AW-1:0]          RS_E,
    output logic [WIDTH-1:0]       SIGN_IMM_E,
    output logic [1:0]             OCC
);

    localparam int PAY_W = DE_CTRL_W + 2*LANES*WIDTH + 3*AW + WIDTH;

    de_ctrl_t         w_ctrl_d;
    de_ctrl_t         w_ctrl_e;
    logic [PAY_W-1:0] w_pay_d;
    logic [PAY_W-1:0] w_pay_e;
    logic             w_valid_e;

    assign w_ctrl_d.reg_write   = REG_WRITE_D;
    assign w_ctrl_d.mem_to_reg  = MEM_TO_REG_D;
    assign w_ctrl_d.mem_write   = MEM_WRITE_D;
    assign w_ctrl_d.alu_control = ALU_CONTROL_D;
    assign w_ctrl_d.alu_src     = ALU_SRC_D;
    assign w_ctrl_d.reg_dst     = REG_DST_D;

    assign w_pay_d = {w_ctrl_d, RD1_D, RD2_D, RA1_D, RA2_D, RS_D, SIGN_IMM_D};

    skid_buf #(
        .W (PAY_W)
    ) u_skid (
        .CLK     (CLK),
        .CLR     (CLR),
        .FLUSH   (FLUSH_D),
        .S_VALID (VALID_D),
        .S_READY (READY_D),
        .S_DATA  (w_pay_d),
        .M_VALID (w_valid_e),
        .M_READY (READY_E),
        .M_DATA  (w_pay_e),
        .OCC     (OCC)
    );

    assign {w_ctrl_e, RD1_E, RD2_E, RA1_E, RA2_E, RS_E, SIGN_IMM_E} = w_pay_e;

    // A bubble must never write the register file or memory.
    assign VALID_E       = w_valid_e;
    assign REG_WRITE_E   = w_ctrl_e.reg_write & w_valid_e;
    assign MEM_WRITE_E   = w_ctrl_e.mem_write & w_valid_e;
    assign MEM_TO_REG_E  = w_ctrl_e.mem_to_reg;
    assign ALU_CONTROL_E = w_ctrl_e.alu_control;
    assign ALU_SRC_E     = w_ctrl_e.alu_src;
    assign REG_DST_E     = w_ctrl_e.reg_dst;

endmodule : pipe_de_hs
`default_nettype wire

// File: tb/tb_pipe_de_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_de_hs
// Description : Directed self-checking bench for pipe_de_hs; LANES=4 is the
//               main instance, LANES=1 and LANES=8 share its controls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_de_hs;

    localparam int WIDTH = 32;
    localparam int AW    = 5;

    logic CLK = 1'b0;
    logic CLR, FLUSH_D, VALID_D, READY_E;
    logic REG_WRITE_D, MEM_TO_REG_D, MEM_WRITE_D, ALU_SRC_D, REG_DST_D;
    logic [3:0]       ALU_CONTROL_D;
    logic [AW-1:0]    RA1_D, RA2_D, RS_D;
    logic [WIDTH-1:0] SIGN_IMM_D;
    logic [31:0]      rd1_d1, rd2_d1;
    logic [127:0]     rd1_d4, rd2_d4;
    logic [255:0]     rd1_d8, rd2_d8;

    // LANES=4 outputs
    logic ready4, valid4, rw4, m2r4, mw4, as4, rdst4;
    logic [3:0] alu4; logic [127:0] rd1_e4, rd2_e4;
    logic [AW-1:0] ra1_4, ra2_4, rs_4; logic [31:0] imm4; logic [1:0] occ4;
    // LANES=1 outputs
    logic ready1, valid1, rw1, m2r1, mw1, as1, rdst1;
    logic [3:0] alu1; logic [31:0] rd1_e1, rd2_e1;
    logic [AW-1:0] ra1_1, ra2_1, rs_1; logic [31:0] imm1; logic [1:0] occ1;
    // LANES=8 outputs
    logic ready8, valid8, rw8, m2r8, mw8, as8, rdst8;
    logic [3:0] alu8; logic [255:0] rd1_e8, rd2_e8;
    logic [AW-1:0] ra1_8, ra2_8, rs_8; logic [31:0] imm8; logic [1:0] occ8;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    pipe_de_hs #(.WIDTH(WIDTH), .LANES(4), .AW(AW)) u_dut4 (
        .CLK(CLK), .CLR(CLR), .FLUSH_D(FLUSH_D), .VALID_D(VALID_D), .READY_D(ready4),
        .REG_WRITE_D(REG_WRITE_D), .MEM_TO_REG_D(MEM_TO_REG_D), .MEM_WRITE_D(MEM_WRITE_D),
        .ALU_SRC_D(ALU_SRC_D), .REG_DST_D(REG_DST_D), .ALU_CONTROL_D(ALU_CONTROL_D),
        .RD1_D(rd1_d4), .RD2_D(rd2_d4), .RA1_D(RA1_D), .RA2_D(RA2_D), .RS_D(RS_D),
        .SIGN_IMM_D(SIGN_IMM_D), .VALID_E(valid4), .READY_E(READY_E),
        .REG_WRITE_E(rw4), .MEM_TO_REG_E(m2r4), .MEM_WRITE_E(mw4), .ALU_SRC_E(as4),
        .REG_DST_E(rdst4), .ALU_CONTROL_E(alu4), .RD1_E(rd1_e4), .RD2_E(rd2_e4),
        .RA1_E(ra1_4), .RA2_E(ra2_4), .RS_E(rs_4), .SIGN_IMM_E(imm4), .OCC(occ4));

    pipe_de_hs #(.WIDTH(WIDTH), .LANES(1), .AW(AW)) u_dut1 (
        .CLK(CLK), .CLR(CLR), .FLUSH_D(FLUSH_D), .VALID_D(VALID_D), .READY_D(ready1),
        .REG_WRITE_D(REG_WRITE_D), .MEM_TO_REG_D(MEM_TO_REG_D), .MEM_WRITE_D(MEM_WRITE_D),
        .ALU_SRC_D(ALU_SRC_D), .REG_DST_D(REG_DST_D), .ALU_CONTROL_D(ALU_CONTROL_D),
        .RD1_D(rd1_d1), .RD2_D(rd2_d1), .RA1_D(RA1_D), .RA2_D(RA2_D), .RS_D(RS_D),
        .SIGN_IMM_D(SIGN_IMM_D), .VALID_E(valid1), .READY_E(READY_E),
        .REG_WRITE_E(rw1), .MEM_TO_REG_E(m2r1), .MEM_WRITE_E(mw1), .ALU_SRC_E(as1),
        .REG_DST_E(rdst1), .ALU_CONTROL_E(alu1), .RD1_E(rd1_e1), .RD2_E(rd2_e1),
        .RA1_E(ra1_1), .RA2_E(ra2_1), .RS_E(rs_1), .SIGN_IMM_E(imm1), .OCC(occ1));

    pipe_de_hs #(.WIDTH(WIDTH), .LANES(8), .AW(AW)) u_dut8 (
        .CLK(CLK), .CLR(CLR), .FLUSH_D(FLUSH_D), .VALID_D(VALID_D), .READY_D(ready8),
        .REG_WRITE_D(REG_WRITE_D), .MEM_TO_REG_D(MEM_TO_REG_D), .MEM_WRITE_D(MEM_WRITE_D),
        .ALU_SRC_D(ALU_SRC_D), .REG_DST_D(REG_DST_D), .ALU_CONTROL_D(ALU_CONTROL_D),
        .RD1_D(rd1_d8), .RD2_D(rd2_d8), .RA1_D(RA1_D), .RA2_D(RA2_D), .RS_D(RS_D),
        .SIGN_IMM_D(SIGN_IMM_D), .VALID_E(valid8), .READY_E(READY_E),
        .REG_WRITE_E(rw8), .MEM_TO_REG_E(m2r8), .MEM_WRITE_E(mw8), .ALU_SRC_E(as8),
        .REG_DST_E(rdst8), .ALU_CONTROL_E(alu8), .RD1_E(rd1_e8), .RD2_E(rd2_e8),
        .RA1_E(ra1_8), .RA2_E(ra2_8), .RS_E(rs_8), .SIGN_IMM_E(imm8), .OCC(occ8));

    // Lane pattern: lane i = base + i + beat.
    function automatic logic [511:0] lanes(input int n, input int b, input logic [31:0] base);
        logic [511:0] v;
        v = '0;
        for (int i = 0; i < n; i++) begin
            v[i*32 +: 32] = base + 32'(i) + 32'(b);
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic v, input logic rw, input logic mw,
                          input logic [31:0] imm, input int b);
        logic [511:0] t;
        VALID_D       = v;
        REG_WRITE_D   = rw;
        MEM_WRITE_D   = mw;
        MEM_TO_REG_D  = b[0];
        ALU_SRC_D     = b[1];
        REG_DST_D     = b[2];
        ALU_CONTROL_D = imm[3:0];
        SIGN_IMM_D    = imm;
        RA1_D         = AW'(b);
        RA2_D         = AW'(b + 1);
        RS_D          = AW'(b + 2);
        t = lanes(1, b, 32'h1000_0000); rd1_d1 = t[31:0];
        t = lanes(1, b, 32'h2000_0000); rd2_d1 = t[31:0];
        t = lanes(4, b, 32'h1000_0000); rd1_d4 = t[127:0];
        t = lanes(4, b, 32'h2000_0000); rd2_d4 = t[127:0];
        t = lanes(8, b, 32'h1000_0000); rd1_d8 = t[255:0];
        t = lanes(8, b, 32'h2000_0000); rd2_d8 = t[255:0];
    endtask

    initial begin
        // Reset held two cycles with random inputs offered
        CLR = 1'b1; FLUSH_D = 1'b0; READY_E = 1'($urandom);
        set_in(1'b1, 1'($urandom), 1'($urandom), $urandom, int'($urandom_range(0, 31)));
        step();
        set_in(1'b1, 1'b1, 1'b1, $urandom, int'($urandom_range(0, 31)));
        step();
        chk("rst_valid_e", valid4, 0);
        chk("rst_ready_d", ready4, 1);
        chk("rst_occ", occ4, 0);
        chk("rst_rw_e", rw4, 0);
        chk("rst_mw_e", mw4, 0);
        chk("rst_alu_e", alu4, 0);
        chk("rst_imm_e", imm4, 0);
        chk("rst_rd1_e", rd1_e4, 0);
        chk("rst_rd2_e", rd2_e4, 0);
        chk("rst_ra1_e", ra1_4, 0);
        chk("rst_rd1_e8", rd1_e8, 0);
        CLR = 1'b0;

        // Streaming, 1-cycle latency, skid stays empty
        READY_E = 1'b1;
        for (int b = 0; b < 10; b++) begin
            set_in(1'b1, 1'b1, 1'b0, 32'h100 + 32'(b), b);
            step();
            chk("str_valid", valid4, 1);
            chk("str_occ", occ4, 1);
            chk("str_ready", ready4, 1);
            chk("str_rw", rw4, 1);
            chk("str_mw", mw4, 0);
            chk("str_m2r", m2r4, b[0]);
            chk("str_rdst", rdst4, b[2]);
            chk("str_alu", alu4, b[3:0]);
            chk("str_imm", imm4, 32'h100 + 32'(b));
            chk("str_ra2", ra2_4, AW'(b + 1));
            chk("str_rs", rs_4, AW'(b + 2));
            chk("str_rd1_l4", rd1_e4, lanes(4, b, 32'h1000_0000));
            chk("str_rd2_l4", rd2_e4, lanes(4, b, 32'h2000_0000));
            chk("str_rd1_l1", rd1_e1, lanes(1, b, 32'h1000_0000));
            chk("str_rd1_l8", rd1_e8, lanes(8, b, 32'h1000_0000));
            chk("str_rd2_l8", rd2_e8, lanes(8, b, 32'h2000_0000));
        end
        VALID_D = 1'b0;
        step();
        chk("str_end_valid", valid4, 0);
        chk("str_end_occ", occ4, 0);

        // Stall and skid: A out, B into skid, C refused until space
        set_in(1'b1, 1'b1, 1'b0, 32'hA0, 20);
        step();
        chk("sk_a_imm", imm4, 32'hA0);
        chk("sk_a_occ", occ4, 1);
        READY_E = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 32'hB0, 21);
        step();
        chk("sk_b_imm", imm4, 32'hA0);
        chk("sk_b_occ", occ4, 2);
        chk("sk_b_ready", ready4, 0);
        chk("sk_b_valid", valid4, 1);
        set_in(1'b1, 1'b1, 1'b0, 32'hC0, 22);
        step();
        chk("sk_c_imm", imm4, 32'hA0);
        chk("sk_c_occ", occ4, 2);
        chk("sk_c_ready", ready4, 0);
        READY_E = 1'b1;
        step();
        chk("sk_rel_imm", imm4, 32'hB0);
        chk("sk_rel_rd1", rd1_e4, lanes(4, 21, 32'h1000_0000));
        chk("sk_rel_occ", occ4, 1);
        chk("sk_rel_ready", ready4, 1);
        step();
        chk("sk_c_out_imm", imm4, 32'hC0);
        chk("sk_c_out_occ", occ4, 1);
        VALID_D = 1'b0;
        step();
        chk("sk_end_valid", valid4, 0);
        chk("sk_end_occ", occ4, 0);

        // Flush at OCC=2 with an incoming memory-write beat
        set_in(1'b1, 1'b0, 1'b0, 32'hD0, 23);
        step();
        chk("fl_d_occ", occ4, 1);
        READY_E = 1'b0;
        set_in(1'b1, 1'b0, 1'b0, 32'hE0, 24);
        step();
        chk("fl_e_occ", occ4, 2);
        FLUSH_D = 1'b1;
        set_in(1'b1, 1'b1, 1'b1, 32'hF0, 25);
        step();
        chk("fl_valid", valid4, 0);
        chk("fl_mw", mw4, 0);
        chk("fl_rw", rw4, 0);
        chk("fl_occ", occ4, 0);
        chk("fl_ready", ready4, 1);
        chk("fl_stale_imm", imm4, 32'hD0);
        FLUSH_D = 1'b0; VALID_D = 1'b0; READY_E = 1'b1;
        step();
        chk("fl_post_valid", valid4, 0);
        chk("fl_post_occ", occ4, 0);

        // Bubble gating of write enables with stale payload visible
        set_in(1'b1, 1'b1, 1'b1, 32'h1234, 26);
        step();
        chk("bg_valid", valid4, 1);
        chk("bg_rw", rw4, 1);
        chk("bg_mw", mw4, 1);
        VALID_D = 1'b0;
        step();
        chk("bg_b_valid", valid4, 0);
        chk("bg_b_rw", rw4, 0);
        chk("bg_b_mw", mw4, 0);
        chk("bg_b_imm", imm4, 32'h1234);

        // Clear mid-stall with both slots full
        READY_E = 1'b0;
        set_in(1'b1, 1'b1, 1'b1, 32'h55, 27);
        step();
        set_in(1'b1, 1'b1, 1'b1, 32'h66, 28);
        step();
        chk("cl_pre_occ", occ4, 2);
        CLR = 1'b1;
        step();
        chk("cl_occ", occ4, 0);
        chk("cl_ready", ready4, 1);
        chk("cl_valid", valid4, 0);
        chk("cl_imm", imm4, 0);
        CLR = 1'b0; VALID_D = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipe_de_hs
`default_nettype wire
